// File: rtl/fir_decim_fifo_pkg.sv
// Shared constants and types for the FIR decimator / FIFO output stage.
// FIR_DATA_W is also the output width of the fir_lp filter feeding this stage.
package fir_decim_fifo_pkg;

  localparam int FIR_DATA_W         = 32;
  localparam int FIR_DECIM_DEF      = 4;
  localparam int FIR_FIFO_DEPTH_DEF = 8;

  // The bit order is {write, read}, which matches the FIFO's level update.
  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_POP  = 2'b01,
    FIFO_PUSH = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

  // A counter always needs at least one bit, even when DECIM is 1.
  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fir_decim_fifo_fwft.sv
// First-word-fall-through synchronous FIFO. The head word is readable
// combinationally whenever the FIFO is non-empty, and rd_data is zero when it is empty.
module sync_fifo_fwft
  import fir_decim_fifo_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_FIFO_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       level
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wrPtr_q, wrPtr_d;
  logic [AW-1:0]     rdPtr_q, rdPtr_d;
  logic [AW:0]       level_q, level_d;
  logic              wrOk, rdOk;
  fifo_op_e          op;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW + 1)'(DEPTH));
  assign level = level_q;

  // On a full FIFO a write is accepted only together with a read. The write
  // then lands in the slot that the read is freeing.
  assign rdOk = rd_en && !empty;
  assign wrOk = wr_en && (!full || rdOk);
  assign op   = fifo_op_e'({wrOk, rdOk});

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    level_d = level_q;
    if (wrOk) wrPtr_d = wrPtr_q + 1'b1;
    if (rdOk) rdPtr_d = rdPtr_q + 1'b1;
    case (op)
      FIFO_PUSH: level_d = level_q + 1'b1;
      FIFO_POP:  level_d = level_q - 1'b1;
      default:   level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      level_q <= level_d;
    end
  end

  // The storage has no reset. Stale words are never seen because rd_data
  // is gated by the empty flag.
  always_ff @(posedge clk) begin
    if (wrOk) mem[wrPtr_q] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rdPtr_q];

endmodule

// File: rtl/fir_decim_fifo.sv
// Keeps 1 of every DECIM enabled FIR samples and buffers the kept samples for a slow
// consumer. When the buffer is full, an extra sample is dropped and the sticky overflow flag is set.
module fir_decim_fifo
  import fir_decim_fifo_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DECIM  = FIR_DECIM_DEF,
  parameter int DEPTH  = FIR_FIFO_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AW:0]       level,
  output logic              overflow,
  input  logic              clr_ovf
);

  localparam int            CW       = cntWidth(DECIM);
  localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, fifoEmpty, fifoFull, wrEn;

  assign push      = in_en && (cnt_q == CNT_LAST);
  assign out_valid = !fifoEmpty;
  assign pop       = out_valid && out_ready;
  assign wrEn      = push && (!fifoFull || pop);
  assign overflow  = overflow_q;

  // The counter advances only on enabled cycles. A set request beats a clear request in the same cycle.
  always_comb begin
    cnt_d      = cnt_q;
    overflow_d = overflow_q;
    if (in_en) cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    if (clr_ovf) overflow_d = 1'b0;
    if (push && fifoFull && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
    end
  end

  sync_fifo_fwft #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wrEn),
    .wr_data(in_data),
    .rd_en  (pop),
    .rd_data(out_data),
    .empty  (fifoEmpty),
    .full   (fifoFull),
    .level  (level)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed self-checking bench for fir_decim_fifo. The main instance uses DECIM=4 and DEPTH=8.
// A second instance uses DECIM=2 and covers the case where in_en toggles.
module tb_fir_decim_fifo;

  logic        clk;
  logic        reset_n;
  logic [31:0] inData, outData;
  logic        inEn, outValid, outReady, overflow, clrOvf;
  logic [3:0]  level;

  logic [31:0] inDataB, outDataB;
  logic        inEnB, outValidB, outReadyB, overflowB;
  logic [3:0]  levelB;

  int testCount = 0;
  int failCount = 0;

  fir_decim_fifo #(.DATA_W(32), .DECIM(4), .DEPTH(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (inData),
    .in_en    (inEn),
    .out_data (outData),
    .out_valid(outValid),
    .out_ready(outReady),
    .level    (level),
    .overflow (overflow),
    .clr_ovf  (clrOvf)
  );

  fir_decim_fifo #(.DATA_W(32), .DECIM(2), .DEPTH(8)) dutB (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (inDataB),
    .in_en    (inEnB),
    .out_data (outDataB),
    .out_valid(outValidB),
    .out_ready(outReadyB),
    .level    (levelB),
    .overflow (overflowB),
    .clr_ovf  (1'b0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every comparison in this bench goes through this task.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the inputs, let one clock edge pass, and settle 1 time unit after that edge.
  task automatic applyStimulus(input logic [31:0] data, input logic en, input logic ready, input logic clr);
    inData   = data;
    inEn     = en;
    outReady = ready;
    clrOvf   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusB(input logic [31:0] data, input logic en);
    inDataB = data;
    inEnB   = en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    inData = '0; inEn = 1'b0; outReady = 1'b0; clrOvf = 1'b0;
    inDataB = '0; inEnB = 1'b0; outReadyB = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_data", outData, 0);
    checkOutput("rst_ovf", overflow, 0);
    reset_n = 1'b1;

    // Test 1: with DECIM=4, samples 4, 8 and 12 are kept.
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(k, 1'b1, 1'b0, 1'b0);
      if (k == 3) checkOutput("t1_valid_before_push", outValid, 0);
      if (k == 4) begin
        checkOutput("t1_first_valid", outValid, 1);
        checkOutput("t1_first_data", outData, 4);
      end
    end
    checkOutput("t1_level", level, 3);
    checkOutput("t1_data_held", outData, 4);

    // Test 2: fill the FIFO, then drop a sample while it is full.
    for (int k = 13; k <= 32; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_level_full", level, 8);
    checkOutput("t2_ovf_before", overflow, 0);
    for (int k = 33; k <= 35; k++) applyStimulus(k, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_ovf_set", overflow, 1);
    checkOutput("t2_level_kept", level, 8);
    checkOutput("t2_head_kept", outData, 4);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t2_drain", outData, 4 * (i + 1));
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("t2_empty_valid", outValid, 0);
    checkOutput("t2_empty_data", outData, 0);
    checkOutput("t2_empty_level", level, 0);
    checkOutput("t2_ovf_sticky", overflow, 1);
    applyStimulus('0, 1'b0, 1'b1, 1'b0);
    checkOutput("t2_empty_ready_level", level, 0);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    checkOutput("t2_ovf_cleared", overflow, 0);

    // Test 3: the FIFO is full; a push and a pop happen on the same edge.
    for (int k = 1; k <= 35; k++) applyStimulus(100 + k, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_level_full", level, 8);
    applyStimulus(136, 1'b1, 1'b1, 1'b0);
    checkOutput("t3_level_stays", level, 8);
    checkOutput("t3_no_ovf", overflow, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("t3_drain", outData, 108 + 4 * i);
      applyStimulus('0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("t3_empty_level", level, 0);

    // Test 5: negative data passes through bit-exact, and set wins over clear.
    for (int k = 1; k <= 4; k++) applyStimulus(32'hFFFF_FFF0, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_neg_data", outData, 32'hFFFF_FFF0);
    checkOutput("t5_level1", level, 1);
    for (int k = 1; k <= 31; k++) applyStimulus(200 + k, 1'b1, 1'b0, 1'b0);
    checkOutput("t5_level_full", level, 8);
    checkOutput("t5_neg_head", outData, 32'hFFFF_FFF0);
    applyStimulus(232, 1'b1, 1'b0, 1'b1);
    checkOutput("t5_set_wins", overflow, 1);
    checkOutput("t5_level_after_drop", level, 8);
    applyStimulus('0, 1'b0, 1'b0, 1'b1);
    checkOutput("t5_clear", overflow, 0);

    // Test 6: assert reset between clock edges while 5 words are stored and overflow is set.
    for (int k = 1; k <= 4; k++) applyStimulus(300 + k, 1'b1, 1'b0, 1'b0);
    checkOutput("t6_ovf_set", overflow, 1);
    for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b1, 1'b0);
    checkOutput("t6_level5", level, 5);
    checkOutput("t6_head", outData, 212);
    outReady = 1'b0;
    #3 reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_valid", outValid, 0);
    checkOutput("t6_rst_level", level, 0);
    checkOutput("t6_rst_data", outData, 0);
    checkOutput("t6_rst_ovf", overflow, 0);
    #2 reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(k, 1'b1, 1'b0, 1'b0);
      if (k == 3) checkOutput("t6_no_early_push", outValid, 0);
      if (k == 4) begin
        checkOutput("t6_push_valid", outValid, 1);
        checkOutput("t6_push_data", outData, 4);
      end
    end
    inEn = 1'b0;

    // Test 4: with DECIM=2 and in_en toggling, one sample is kept every 4 clocks.
    for (int c = 0; c < 8; c++) begin
      applyStimulusB(c + 1, (c % 2) == 0);
      if (c == 1) checkOutput("t4_hold_valid", outValidB, 0);
      if (c == 2) begin
        checkOutput("t4_first_valid", outValidB, 1);
        checkOutput("t4_first_data", outDataB, 3);
      end
      if (c == 5) checkOutput("t4_level1", levelB, 1);
      if (c == 6) checkOutput("t4_level2", levelB, 2);
    end
    checkOutput("t4_head", outDataB, 3);
    checkOutput("t4_no_ovf", overflowB, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
